gshare_pht: RTL and testbench

- Pattern History Table stage directly downstream of the Gshare index generator.
- Consumes the INDEX_W-bit XOR index and returns a registered taken/not-taken prediction from a table of 2-bit saturating counters.
- Holds each issued prediction in an in-order in-flight FIFO until the branch resolves.
- On resolution, trains the counter for the stored index and tallies correct predictions and mispredictions.

---
 rtl/gshare_pht_if.sv | 30 +++
 rtl/gshare_pht.sv | 127 ++++++++++++
 tb/tb_gshare_pht.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gshare_pht_if.sv
// Prediction request, prediction response, resolution and statistics bundle
// between the Gshare index generator / branch unit and the PHT stage.
interface gshare_pht_if #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned STAT_W  = 16
);
  logic               pred_valid;
  logic [INDEX_W-1:0] index_recv;
  logic               pred_ready;
  logic               pred_out_valid;
  logic               pred_taken;
  logic               resolve_valid;
  logic               resolve_taken;
  logic               mispredict;
  logic [STAT_W-1:0]  correct_cnt;
  logic [STAT_W-1:0]  mispred_cnt;
  logic               underflow_err;

  modport master (
    output pred_valid, index_recv, resolve_valid, resolve_taken,
    input  pred_ready, pred_out_valid, pred_taken, mispredict,
           correct_cnt, mispred_cnt, underflow_err
  );

  modport slave (
    input  pred_valid, index_recv, resolve_valid, resolve_taken,
    output pred_ready, pred_out_valid, pred_taken, mispredict,
           correct_cnt, mispred_cnt, underflow_err
  );
endinterface

// File: rtl/gshare_pht.sv
// Gshare pattern history table: 2-bit saturating counters, registered prediction,
// in-order in-flight FIFO of issued predictions, training and accuracy statistics.
module gshare_pht #(
  parameter int unsigned INDEX_W    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STAT_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  gshare_pht_if.slave  bus
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic               pred;
  } entry_t;

  logic [1:0]        pht      [ENTRIES];
  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              pred_out_valid_q;
  logic              pred_taken_q;
  logic              mispredict_q;
  logic              underflow_err_q;
  logic [STAT_W-1:0] correct_cnt_q;
  logic [STAT_W-1:0] mispred_cnt_q;

  logic              pred_ready_c;
  logic              push_c;
  logic              pop_c;
  logic              hit_c;
  entry_t            head_c;
  logic [1:0]        lookup_c;
  logic [1:0]        head_ctr_c;
  logic [1:0]        trained_c;

  // Handshake decode, table lookup and saturating update of the resolving entry
  always_comb begin
    pred_ready_c = (count != CNT_W'(FIFO_DEPTH));
    push_c       = bus.pred_valid && pred_ready_c;
    pop_c        = bus.resolve_valid && (count != '0);
    head_c       = fifo_mem[rd_ptr];
    lookup_c     = pht[bus.index_recv];
    head_ctr_c   = pht[head_c.idx];
    hit_c        = (head_c.pred == bus.resolve_taken);
    trained_c    = head_ctr_c;
    if (bus.resolve_taken) begin
      if (head_ctr_c != 2'b11) trained_c = head_ctr_c + 2'd1;
    end else begin
      if (head_ctr_c != 2'b00) trained_c = head_ctr_c - 2'd1;
    end
  end

  // Counter table; lookups see the pre-edge value, so no same-index bypass
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) pht[i] <= 2'b01;
    end else if (pop_c) begin
      pht[head_c.idx] <= trained_c;
    end
  end

  // In-flight storage; stale contents are harmless once the pointers reset
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= '{idx: bus.index_recv, pred: lookup_c[1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered prediction response
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
    end else begin
      pred_out_valid_q <= push_c;
      if (push_c) pred_taken_q <= lookup_c[1];
    end
  end

  // Resolution statistics and the sticky empty-resolve flag
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q    <= 1'b0;
      underflow_err_q <= 1'b0;
      correct_cnt_q   <= '0;
      mispred_cnt_q   <= '0;
    end else begin
      mispredict_q <= pop_c && !hit_c;
      if (bus.resolve_valid && !pop_c) underflow_err_q <= 1'b1;
      if (pop_c) begin
        if (hit_c) correct_cnt_q <= correct_cnt_q + STAT_W'(1);
        else       mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
      end
    end
  end

  assign bus.pred_ready     = pred_ready_c;
  assign bus.pred_out_valid = pred_out_valid_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.correct_cnt    = correct_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;
  assign bus.underflow_err  = underflow_err_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Directed, table-driven bench for gshare_pht with hand-computed expectations.
module tb_gshare_pht;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gshare_pht_if #(.INDEX_W(4), .STAT_W(16)) bus ();

  gshare_pht #(.INDEX_W(4), .FIFO_DEPTH(4), .STAT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [3:0]  idx;
    logic        rv;
    logic        rt;
    logic        e_pov;
    logic        e_pt;
    logic        e_rdy;
    logic        e_misp;
    logic [15:0] e_corr;
    logic [15:0] e_mcnt;
    logic        e_uf;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic pv, input logic [3:0] idx, input logic rv,
                              input logic rt, input logic pov, input logic pt,
                              input logic rdy, input logic misp, input logic [15:0] corr,
                              input logic [15:0] mcnt, input logic uf);
    vec_t v;
    v.pv = pv; v.idx = idx; v.rv = rv; v.rt = rt;
    v.e_pov = pov; v.e_pt = pt; v.e_rdy = rdy; v.e_misp = misp;
    v.e_corr = corr; v.e_mcnt = mcnt; v.e_uf = uf;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic pv, input logic [3:0] idx, input logic rv,
                      input logic rt, input logic rst);
    bus.pred_valid    = pv;
    bus.index_recv    = idx;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    reset             = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic pov, input logic pt,
                           input logic rdy, input logic misp, input logic [15:0] corr,
                           input logic [15:0] mcnt, input logic uf);
    check({tag, " pred_out_valid"}, 16'(bus.pred_out_valid), 16'(pov));
    check({tag, " pred_taken"},     16'(bus.pred_taken),     16'(pt));
    check({tag, " pred_ready"},     16'(bus.pred_ready),     16'(rdy));
    check({tag, " mispredict"},     16'(bus.mispredict),     16'(misp));
    check({tag, " correct_cnt"},    bus.correct_cnt,         corr);
    check({tag, " mispred_cnt"},    bus.mispred_cnt,         mcnt);
    check({tag, " underflow_err"},  16'(bus.underflow_err),  16'(uf));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //              pv idx rv rt | pov pt rdy misp corr mcnt uf
    vecs[0]  = mk(1, 5, 0, 0,   1, 0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0,   0, 0, 1, 0, 1, 0, 0);
    vecs[2]  = mk(1, 3, 0, 0,   1, 0, 1, 0, 1, 0, 0);
    vecs[3]  = mk(1, 3, 1, 1,   1, 0, 1, 1, 1, 1, 0);
    vecs[4]  = mk(1, 3, 1, 1,   1, 1, 1, 1, 1, 2, 0);
    vecs[5]  = mk(1, 3, 1, 1,   1, 1, 1, 0, 2, 2, 0);
    vecs[6]  = mk(0, 0, 1, 0,   0, 1, 1, 1, 2, 3, 0);
    vecs[7]  = mk(0, 0, 0, 0,   0, 1, 1, 0, 2, 3, 0);
    vecs[8]  = mk(1, 0, 0, 0,   1, 0, 1, 0, 2, 3, 0);
    vecs[9]  = mk(1, 1, 0, 0,   1, 0, 1, 0, 2, 3, 0);
    vecs[10] = mk(1, 2, 0, 0,   1, 0, 1, 0, 2, 3, 0);
    vecs[11] = mk(1, 3, 0, 0,   1, 1, 0, 0, 2, 3, 0);
    vecs[12] = mk(1, 6, 0, 0,   0, 1, 0, 0, 2, 3, 0);
    vecs[13] = mk(1, 6, 1, 1,   0, 1, 1, 1, 2, 4, 0);
    vecs[14] = mk(0, 0, 1, 1,   0, 1, 1, 1, 2, 5, 0);
    vecs[15] = mk(0, 0, 1, 0,   0, 1, 1, 0, 3, 5, 0);
    vecs[16] = mk(0, 0, 1, 1,   0, 1, 1, 0, 4, 5, 0);
    vecs[17] = mk(0, 0, 1, 1,   0, 1, 1, 0, 4, 5, 1);
    vecs[18] = mk(0, 0, 0, 0,   0, 1, 1, 0, 4, 5, 1);
    vecs[19] = mk(1, 0, 1, 1,   1, 1, 1, 0, 4, 5, 1);
    vecs[20] = mk(0, 0, 1, 1,   0, 1, 1, 0, 5, 5, 1);
    vecs[21] = mk(1, 7, 0, 0,   1, 0, 1, 0, 5, 5, 1);
    vecs[22] = mk(1, 7, 1, 1,   1, 0, 1, 1, 5, 6, 1);
    vecs[23] = mk(1, 7, 1, 1,   1, 1, 1, 1, 5, 7, 1);
    vecs[24] = mk(0, 0, 1, 1,   0, 1, 1, 0, 6, 7, 1);

    step(0, 0, 0, 0, 1);
    step(1, 4'h9, 1, 1, 1);
    check_all("reset", 0, 0, 1, 0, 16'd0, 16'd0, 0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].pv, vecs[i].idx, vecs[i].rv, vecs[i].rt, 0);
      check_all($sformatf("v%0d", i), vecs[i].e_pov, vecs[i].e_pt, vecs[i].e_rdy,
                vecs[i].e_misp, vecs[i].e_corr, vecs[i].e_mcnt, vecs[i].e_uf);
    end

    // Reset with three predictions in flight, colliding with a request and a resolve
    step(1, 4'h9, 0, 0, 0);
    step(1, 4'hA, 0, 0, 0);
    step(1, 4'hB, 0, 0, 0);
    check("inflight pred_ready", 16'(bus.pred_ready), 16'd1);
    step(1, 4'hC, 1, 1, 1);
    check_all("rst_inflight", 0, 0, 1, 0, 16'd0, 16'd0, 0);

    // Counter 3 was 11 before reset; it must predict from 01 again
    step(1, 4'h3, 0, 0, 0);
    check_all("post_rst_req", 1, 0, 1, 0, 16'd0, 16'd0, 0);
    step(1, 4'h3, 1, 1, 0);
    check_all("post_rst_train", 1, 0, 1, 1, 16'd0, 16'd1, 0);
    step(1, 4'h3, 0, 0, 0);
    check_all("post_rst_pred", 1, 1, 1, 0, 16'd0, 16'd1, 0);
    step(1, 4'h4, 0, 0, 0);
    check("post_rst_count3 ready", 16'(bus.pred_ready), 16'd1);
    step(1, 4'h4, 0, 0, 0);
    check("post_rst_count4 ready", 16'(bus.pred_ready), 16'd0);

    step(0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
